// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the FFT accelerator, data_mem and dmem_arbiter.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              acc_req;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_base;
    logic [LEN_W-1:0]  acc_len;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_gnt;
    logic [DATA_W-1:0] acc_rdata;
    logic              acc_rvalid;
    logic              acc_done;
    logic              mem_rena;
    logic              mem_wena;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [31:0]       perf_cpu_stall;
    logic [31:0]       perf_acc_beats;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  acc_req, acc_we, acc_base, acc_len, acc_wdata,
        output acc_gnt, acc_rdata, acc_rvalid, acc_done,
        output mem_rena, mem_wena, mem_addr, mem_wdata,
        input  mem_rdata,
        output perf_cpu_stall, perf_acc_beats
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output acc_req, acc_we, acc_base, acc_len, acc_wdata,
        input  acc_gnt, acc_rdata, acc_rvalid, acc_done,
        input  mem_rena, mem_wena, mem_addr, mem_wdata,
        output mem_rdata,
        input  perf_cpu_stall, perf_acc_beats
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU single accesses with fixed priority, ACC bursts, starvation counters.
// Optional perf counters enabled by defining DMEM_ARB_PERF_CNT_EN.
module dmem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  acc_wait_q, acc_wait_d;
    logic [CNT_W-1:0]  cpu_starve_q, cpu_starve_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] acc_rdata_q, acc_rdata_d;
    logic              acc_rvalid_q, acc_rvalid_d;
    logic              acc_done_q, acc_done_d;

    logic              cpu_gnt_raw_s, acc_gnt_raw_s;
    logic              cpu_gnt_s, acc_gnt_s, cpu_stall_s;
    logic              beat_we_s;
    logic [ADDR_W-1:0] beat_addr_s;
    logic [LEN_W-1:0]  req_len_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
    endfunction

    // Grants are suppressed while reset is held so the memory port stays quiet
    assign cpu_gnt_s   = cpu_gnt_raw_s & rst;
    assign acc_gnt_s   = acc_gnt_raw_s & rst;
    assign cpu_stall_s = bus.cpu_req & ~cpu_gnt_s & rst;

    // Arbitration FSM: next state, grants and counter updates
    always_comb begin
        state_d       = state_q;
        acc_wait_d    = acc_wait_q;
        beat_d        = beat_q;
        len_d         = len_q;
        base_d        = base_q;
        we_d          = we_q;
        acc_done_d    = 1'b0;
        cpu_gnt_raw_s = 1'b0;
        acc_gnt_raw_s = 1'b0;
        beat_we_s     = 1'b0;
        beat_addr_s   = {ADDR_W{1'b0}};
        req_len_s     = (bus.acc_len == {LEN_W{1'b0}}) ? LEN_W'(1) : bus.acc_len;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req && (acc_wait_q < LIMIT)) begin
                    cpu_gnt_raw_s = 1'b1;
                    acc_wait_d    = bus.acc_req ? sat_inc(acc_wait_q) : {CNT_W{1'b0}};
                end else if (bus.acc_req) begin
                    acc_gnt_raw_s = 1'b1;
                    beat_we_s     = bus.acc_we;
                    beat_addr_s   = bus.acc_base;
                    acc_wait_d    = {CNT_W{1'b0}};
                    base_d        = bus.acc_base;
                    len_d         = req_len_s;
                    we_d          = bus.acc_we;
                    if (req_len_s == LEN_W'(1)) begin
                        acc_done_d = 1'b1;
                    end else begin
                        beat_d  = LEN_W'(1);
                        state_d = BURST;
                    end
                end else begin
                    acc_wait_d = {CNT_W{1'b0}};
                end
            end
            BURST: begin
                if (!bus.acc_req) begin
                    // Abort: memory is free this cycle, so a waiting CPU may use it
                    cpu_gnt_raw_s = bus.cpu_req;
                    state_d       = IDLE;
                end else if (bus.cpu_req && (cpu_starve_q == LIMIT)) begin
                    cpu_gnt_raw_s = 1'b1;
                end else begin
                    acc_gnt_raw_s = 1'b1;
                    beat_we_s     = we_q;
                    beat_addr_s   = base_q + ADDR_W'(beat_q);
                    beat_d        = beat_q + LEN_W'(1);
                    if (beat_q == (len_q - LEN_W'(1))) begin
                        state_d    = IDLE;
                        acc_done_d = 1'b1;
                    end else begin
                        state_d    = BURST;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cpu_starve_d = (bus.cpu_req && !cpu_gnt_raw_s) ? sat_inc(cpu_starve_q) : {CNT_W{1'b0}};
        acc_rvalid_d = acc_gnt_raw_s & ~beat_we_s;
        acc_rdata_d  = acc_rvalid_d ? bus.mem_rdata : acc_rdata_q;
    end

    // Memory port mux of the granted requester
    always_comb begin
        bus.mem_rena  = 1'b0;
        bus.mem_wena  = 1'b0;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        if (cpu_gnt_s) begin
            bus.mem_rena  = ~bus.cpu_we;
            bus.mem_wena  = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (acc_gnt_s) begin
            bus.mem_rena  = ~beat_we_s;
            bus.mem_wena  = beat_we_s;
            bus.mem_addr  = beat_addr_s;
            bus.mem_wdata = bus.acc_wdata;
        end else begin
            bus.mem_rena  = 1'b0;
            bus.mem_wena  = 1'b0;
        end
    end

    // FSM state, counters and registered ACC response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            acc_wait_q   <= {CNT_W{1'b0}};
            cpu_starve_q <= {CNT_W{1'b0}};
            beat_q       <= {LEN_W{1'b0}};
            len_q        <= {LEN_W{1'b0}};
            base_q       <= {ADDR_W{1'b0}};
            we_q         <= 1'b0;
            acc_rdata_q  <= {DATA_W{1'b0}};
            acc_rvalid_q <= 1'b0;
            acc_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_wait_q   <= acc_wait_d;
            cpu_starve_q <= cpu_starve_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            base_q       <= base_d;
            we_q         <= we_d;
            acc_rdata_q  <= acc_rdata_d;
            acc_rvalid_q <= acc_rvalid_d;
            acc_done_q   <= acc_done_d;
        end
    end

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = cpu_stall_s;
    assign bus.acc_gnt    = acc_gnt_s;
    assign bus.acc_rdata  = acc_rdata_q;
    assign bus.acc_rvalid = acc_rvalid_q;
    assign bus.acc_done   = acc_done_q;

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_beats_q;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= 32'd0;
            perf_beats_q <= 32'd0;
        end else begin
            if (cpu_stall_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
            if (acc_gnt_s && (perf_beats_q != 32'hFFFF_FFFF)) begin
                perf_beats_q <= perf_beats_q + 32'd1;
            end else begin
                perf_beats_q <= perf_beats_q;
            end
        end
    end

    assign bus.perf_cpu_stall = perf_stall_q;
    assign bus.perf_acc_beats = perf_beats_q;
`else
    assign bus.perf_cpu_stall = 32'd0;
    assign bus.perf_acc_beats = 32'd0;
`endif

endmodule
